mem_arbiter_n: RTL and testbench
================================

# mem_arbiter_n

Parametrised N-port line-memory arbiter for the cache hierarchy, generalising the two-port instruction/data arbiter that sits between the L1 caches and L2/physical memory. Accepts whole-line read/write requests from `NUM_PORTS` upstream caches, grants one at a time, and forwards it to a single downstream memory port. Latches the granted request and registers the returned line. Uses round-robin or fixed-priority grant, selected at compile time.

## Interface
- `NUM_PORTS`, 2: number of upstream requesters, range 2–8.
- `ADDR_W`, 32: address width.
- `LINE_W`, 256: cache line width.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req_read` in `NUM_PORTS`: per-port line read request, held until that port's `req_resp`.
- `req_write` in `NUM_PORTS`: per-port line write request, held until that port's `req_resp`.
- `req_address` in `NUM_PORTS*ADDR_W`: port p occupies bits `[p*ADDR_W +: ADDR_W]`.
- `req_wdata` in `NUM_PORTS*LINE_W`: port p occupies bits `[p*LINE_W +: LINE_W]`.
- `req_resp` out `NUM_PORTS`: one-hot, one-cycle completion pulse.
- `req_rdata` out `LINE_W`: shared read line; valid only while `req_resp` is nonzero.
- `mem_read` out 1: downstream read request.
- `mem_write` out 1: downstream write request.
- `mem_address` out `ADDR_W`: downstream address.
- `mem_wdata` out `LINE_W`: downstream write line.
- `mem_resp` in 1: downstream completion, one-cycle pulse.
- `mem_rdata` in `LINE_W`: downstream read line; valid with `mem_resp`.

## Operation
- State machine: IDLE, BUSY, RESP. Reset state is IDLE.
- **IDLE**
  - Port p is requesting when `req_read[p] | req_write[p]`.
  - If any port is requesting, select grant g, latch `g`, op, `req_address[g]` and `req_wdata[g]`, then go to BUSY.
  - If no port is requesting, stay in IDLE.
- **BUSY**
  - `mem_read`/`mem_write` reflect the latched op; `mem_address`/`mem_wdata` drive the latched values.
  - Outputs stay stable until `mem_resp`.
  - On `mem_resp`: register `mem_rdata` into `req_rdata`, go to RESP.
- **RESP**
  - `req_resp[g]`=1 for exactly one cycle; `mem_read`/`mem_write`=0.
  - Always go to IDLE next.
- A port with both `req_read` and `req_write` asserted is treated as a write.
- Upstream changes during BUSY are ignored. A granted port that drops its request mid-transaction still completes and still receives `req_resp`.
- `mem_resp` outside BUSY is ignored.
- Grant selection when round-robin is compiled in:
  - Priority pointer `ptr` (`$clog2(NUM_PORTS)` bits). Search from `ptr` upward, wrapping modulo `NUM_PORTS`; the first requesting port wins.
  - On grant, `ptr` ← (g+1) mod `NUM_PORTS`, including wrap from `NUM_PORTS-1` to 0.
- Reset values:
  - state=IDLE, `ptr`=0, `mem_read`=`mem_write`=0, `mem_address`=0, `mem_wdata`=0, `req_resp`=0, `req_rdata`=0.
- Reset mid-transaction takes priority over everything: downstream requests drop in the cycle following the reset edge, and no `req_resp` is issued for the aborted transaction.

## Timing
- Cycle 0, IDLE with request present: grant registered at the end of cycle 0.
- Cycle 1: `mem_read`/`mem_write` asserted.
- `mem_resp` in cycle k (k≥1) → `req_resp` in cycle k+1 → IDLE in cycle k+2.
- Minimum request-to-response latency: downstream latency + 2 cycles.
- Minimum back-to-back spacing: one IDLE cycle between transactions.
- A requester samples `req_resp` and deasserts its request in the next cycle, which is the IDLE cycle, so no stale regrant occurs.
- All outputs are registered; there is no combinational path from `req_*` or `mem_resp` to any output.

## Configuration
- `MEM_ARB_RR_EN` defined: round-robin grant as described under Operation.
- `MEM_ARB_RR_EN` undefined: fixed priority, lowest requesting index wins. `ptr` is not implemented. All other behaviour and timing are identical.

## Test plan
- **Single read, port 1:** `NUM_PORTS`=4, port 1 reads 0x0000_1040, memory responds 3 cycles after `mem_read` with line 0xA5..A5 → `mem_address`=0x1040 from cycle 1; `req_resp`=4'b0010 for one cycle with `req_rdata`=0xA5..A5; no other port responds.
- **Write passthrough:** port 0 writes 0x0000_2000 with line 0x1234..; port 0 also asserts read → write wins; `mem_write`=1, `mem_read`=0, `mem_wdata` matches; `req_resp[0]` pulses.
- **Round-robin fairness (`MEM_ARB_RR_EN`):** all 4 ports request continuously → grants in order 0,1,2,3,0; `ptr` wraps 3→0. Without the macro → port 0 is granted every time.
- **Stability under upstream change:** during BUSY, change `req_address[g]` and assert other ports → `mem_address` unchanged until `mem_resp`; the next grant follows the rotation.
- **Reset mid-BUSY:** assert `rst` two cycles after the grant → next cycle `mem_read`=0, state=IDLE, `ptr`=0; a later `mem_resp` is ignored and produces no `req_resp`.
- **Spurious `mem_resp` in IDLE:** pulse `mem_resp` with no request pending → no `req_resp`; `req_rdata` holds its previous value.

Source files
------------

// File: rtl/mem_arbiter_n_if.sv
// Bus bundle for mem_arbiter_n: upstream cache request ports plus the single
// downstream memory port. The slave modport is the arbiter's view and the
// master modport is the environment's view (caches and memory together).
interface mem_arbiter_n_if #(
  parameter int NUM_PORTS = 2,
  parameter int ADDR_W    = 32,
  parameter int LINE_W    = 256
) ();
  logic [NUM_PORTS-1:0]        req_read;
  logic [NUM_PORTS-1:0]        req_write;
  logic [NUM_PORTS*ADDR_W-1:0] req_address;
  logic [NUM_PORTS*LINE_W-1:0] req_wdata;
  logic [NUM_PORTS-1:0]        req_resp;
  logic [LINE_W-1:0]           req_rdata;
  logic                        mem_read;
  logic                        mem_write;
  logic [ADDR_W-1:0]           mem_address;
  logic [LINE_W-1:0]           mem_wdata;
  logic                        mem_resp;
  logic [LINE_W-1:0]           mem_rdata;

  modport slave (
    input  req_read, req_write, req_address, req_wdata, mem_resp, mem_rdata,
    output req_resp, req_rdata, mem_read, mem_write, mem_address, mem_wdata
  );

  modport master (
    output req_read, req_write, req_address, req_wdata, mem_resp, mem_rdata,
    input  req_resp, req_rdata, mem_read, mem_write, mem_address, mem_wdata
  );
endinterface

// File: rtl/mem_arbiter_n.sv
// N-port whole-line memory arbiter. Grants one upstream request at a time,
// latches it, forwards it downstream and returns the registered line with a
// one-cycle one-hot completion pulse. All outputs are registered.
// Compile-time option: define MEM_ARB_RR_EN for round-robin grant; otherwise
// the lowest requesting index wins.
//
// state | meaning
// IDLE  | waiting for any request; grant is taken at the end of this cycle
// BUSY  | latched request driven downstream until mem_resp
// RESP  | req_resp pulse to the granted port, downstream request dropped
module mem_arbiter_n #(
  parameter int NUM_PORTS = 2,
  parameter int ADDR_W    = 32,
  parameter int LINE_W    = 256
) (
  input  logic             clk,
  input  logic             rst,
  mem_arbiter_n_if.slave   bus
);
  localparam int GW = $clog2(NUM_PORTS);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [GW-1:0]          r_grant;
  logic                   r_mem_read;
  logic                   r_mem_write;
  logic [ADDR_W-1:0]      r_address;
  logic [LINE_W-1:0]      r_wdata;
  logic [LINE_W-1:0]      r_rdata;
  logic [NUM_PORTS-1:0]   r_resp;
  logic [NUM_PORTS-1:0]   w_req;
  logic [GW-1:0]          w_gnt;
  logic                   w_gnt_vld;
`ifdef MEM_ARB_RR_EN
  logic [GW-1:0]          r_ptr;
`endif

  assign w_req = bus.req_read | bus.req_write;

`ifdef MEM_ARB_RR_EN
  // Round-robin search: first requester at or above r_ptr, wrapping.
  always_comb begin
    int j;
    j         = 0;
    w_gnt     = '0;
    w_gnt_vld = 1'b0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      j = int'(r_ptr) + i;
      if (j >= NUM_PORTS) j = j - NUM_PORTS;
      if (!w_gnt_vld && w_req[j]) begin
        w_gnt     = GW'(j);
        w_gnt_vld = 1'b1;
      end
    end
  end
`else
  // Fixed priority: scanning downward leaves the lowest requester selected.
  always_comb begin
    w_gnt     = '0;
    w_gnt_vld = 1'b0;
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
      if (w_req[i]) begin
        w_gnt     = GW'(i);
        w_gnt_vld = 1'b1;
      end
    end
  end
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state logic; mem_resp only matters while BUSY.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_gnt_vld) w_state_nxt = BUSY;
      BUSY:    if (bus.mem_resp) w_state_nxt = RESP;
      RESP:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Request latch, downstream drive and response registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_grant     <= '0;
      r_mem_read  <= 1'b0;
      r_mem_write <= 1'b0;
      r_address   <= '0;
      r_wdata     <= '0;
      r_rdata     <= '0;
      r_resp      <= '0;
`ifdef MEM_ARB_RR_EN
      r_ptr       <= '0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          r_resp <= '0;
          if (w_gnt_vld) begin
            r_grant     <= w_gnt;
            r_address   <= bus.req_address[int'(w_gnt)*ADDR_W +: ADDR_W];
            r_wdata     <= bus.req_wdata[int'(w_gnt)*LINE_W +: LINE_W];
            // read+write together is treated as a write
            r_mem_write <= bus.req_write[w_gnt];
            r_mem_read  <= ~bus.req_write[w_gnt];
`ifdef MEM_ARB_RR_EN
            if (int'(w_gnt) == NUM_PORTS - 1) r_ptr <= '0;
            else                              r_ptr <= w_gnt + GW'(1);
`endif
          end
        end
        BUSY: begin
          if (bus.mem_resp) begin
            r_rdata     <= bus.mem_rdata;
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
            r_resp      <= {{(NUM_PORTS-1){1'b0}}, 1'b1} << r_grant;
          end
        end
        RESP: begin
          r_resp <= '0;
        end
        default: begin
          r_resp      <= '0;
          r_mem_read  <= 1'b0;
          r_mem_write <= 1'b0;
        end
      endcase
    end
  end

  assign bus.mem_read    = r_mem_read;
  assign bus.mem_write   = r_mem_write;
  assign bus.mem_address = r_address;
  assign bus.mem_wdata   = r_wdata;
  assign bus.req_resp    = r_resp;
  assign bus.req_rdata   = r_rdata;
endmodule

// File: tb/tb_mem_arbiter_n.sv
// Bench for mem_arbiter_n with four ports. Grant order and returned data are
// predicted from a small reference model (priority pointer as an integer,
// search over the request mask). Works with or without MEM_ARB_RR_EN.
module tb_mem_arbiter_n;
  localparam int N  = 4;
  localparam int AW = 32;
  localparam int LW = 256;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_arbiter_n_if #(.NUM_PORTS(N), .ADDR_W(AW), .LINE_W(LW)) bus ();

  mem_arbiter_n #(.NUM_PORTS(N), .ADDR_W(AW), .LINE_W(LW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;

  // reference model state
  int            m_ptr   = 0;
  logic [LW-1:0] m_rdata = '0;

  task automatic chk(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [LW-1:0] rand_line();
    logic [LW-1:0] l;
    for (int i = 0; i < LW / 32; i++) l[i*32 +: 32] = $urandom;
    return l;
  endfunction

  function automatic int model_grant(input logic [N-1:0] reqs);
    int p;
    for (int i = 0; i < N; i++) begin
`ifdef MEM_ARB_RR_EN
      p = (m_ptr + i) % N;
`else
      p = i;
`endif
      if (reqs[p]) return p;
    end
    return -1;
  endfunction

  // Entered at the negedge of an IDLE cycle with requests already driven.
  // Returns at the negedge of the following IDLE cycle.
  task automatic run_txn(input int lat, input bit perturb, input bit keep);
    int            g;
    bit            exp_wr;
    logic [AW-1:0] exp_addr;
    logic [LW-1:0] exp_wd;
    logic [LW-1:0] line;
    logic [N-1:0]  oh;
    g = model_grant(bus.req_read | bus.req_write);
    if (g < 0) begin
      chk("model_no_request", 1'b0, 1'b1);
      return;
    end
    exp_wr   = bus.req_write[g];
    exp_addr = bus.req_address[g*AW +: AW];
    exp_wd   = bus.req_wdata[g*LW +: LW];
    m_ptr    = (g + 1) % N;
    oh       = 4'b0001 << g;
    line     = rand_line();

    @(negedge clk);
    chk("busy_mem_read", bus.mem_read, !exp_wr);
    chk("busy_mem_write", bus.mem_write, exp_wr);
    chk("busy_mem_address", bus.mem_address, exp_addr);
    chk("busy_mem_wdata", bus.mem_wdata, exp_wd);
    chk("busy_no_resp", bus.req_resp, '0);
    if (perturb) begin
      for (int p = 0; p < N; p++) bus.req_address[p*AW +: AW] = $urandom;
      bus.req_read = '1;
    end
    if (lat == 1) begin
      bus.mem_resp  = 1'b1;
      bus.mem_rdata = line;
    end
    for (int c = 2; c <= lat; c++) begin
      @(negedge clk);
      chk("hold_mem_address", bus.mem_address, exp_addr);
      chk("hold_mem_op", {bus.mem_read, bus.mem_write}, {!exp_wr, exp_wr});
      chk("hold_no_resp", bus.req_resp, '0);
      if (c == lat) begin
        bus.mem_resp  = 1'b1;
        bus.mem_rdata = line;
      end
    end

    @(negedge clk);
    bus.mem_resp  = 1'b0;
    bus.mem_rdata = rand_line();
    m_rdata       = line;
    chk("resp_onehot", bus.req_resp, oh);
    chk("resp_rdata", bus.req_rdata, m_rdata);
    chk("resp_mem_idle", {bus.mem_read, bus.mem_write}, 2'b00);
    if (!keep) begin
      bus.req_read[g]  = 1'b0;
      bus.req_write[g] = 1'b0;
    end

    @(negedge clk);
    chk("idle_resp_clear", bus.req_resp, '0);
    chk("idle_mem_idle", {bus.mem_read, bus.mem_write}, 2'b00);
  endtask

  initial begin
    logic [N-1:0] rm, wm;
    bus.req_read    = '0;
    bus.req_write   = '0;
    bus.req_address = '0;
    bus.req_wdata   = '0;
    bus.mem_resp    = 1'b0;
    bus.mem_rdata   = '0;

    // reset values
    @(negedge clk);
    @(negedge clk);
    chk("rst_mem_op", {bus.mem_read, bus.mem_write}, 2'b00);
    chk("rst_mem_address", bus.mem_address, '0);
    chk("rst_mem_wdata", bus.mem_wdata, '0);
    chk("rst_req_resp", bus.req_resp, '0);
    chk("rst_req_rdata", bus.req_rdata, '0);
    rst = 1'b0;
    @(negedge clk);

    // single read from port 1
    bus.req_read                 = 4'b0010;
    bus.req_address[1*AW +: AW]  = 32'h0000_1040;
    run_txn(4, 1'b0, 1'b0);

    // read+write on port 0 is a write
    bus.req_read                 = 4'b0001;
    bus.req_write                = 4'b0001;
    bus.req_address[0*AW +: AW]  = 32'h0000_2000;
    bus.req_wdata[0*LW +: LW]    = {8{32'h1234_5678}};
    run_txn(2, 1'b0, 1'b0);

    // all ports requesting continuously
    bus.req_read  = '1;
    bus.req_write = '0;
    for (int i = 0; i < N; i++) bus.req_address[i*AW +: AW] = 32'h100 * (i + 1);
    for (int k = 0; k < 5; k++) run_txn(1 + k % 3, 1'b0, 1'b1);

    // upstream change during BUSY, then next grant from the changed mask
    bus.req_read = 4'b0100;
    run_txn(3, 1'b1, 1'b0);
    run_txn(1, 1'b0, 1'b0);
    bus.req_read  = '0;
    bus.req_write = '0;
    @(negedge clk);
    chk("idle_no_request", {bus.mem_read, bus.mem_write}, 2'b00);

    // reset two cycles after the grant
    bus.req_read = 4'b0100;
    @(negedge clk);
    chk("pre_rst_mem_read", bus.mem_read, 1'b1);
    @(negedge clk);
    rst          = 1'b1;
    bus.req_read = '0;
    @(negedge clk);
    rst     = 1'b0;
    m_ptr   = 0;
    m_rdata = '0;
    chk("abort_mem_op", {bus.mem_read, bus.mem_write}, 2'b00);
    chk("abort_no_resp", bus.req_resp, '0);
    chk("abort_rdata", bus.req_rdata, '0);
    bus.mem_resp  = 1'b1;
    bus.mem_rdata = rand_line();
    @(negedge clk);
    bus.mem_resp = 1'b0;
    chk("late_mem_resp_ignored", bus.req_resp, '0);
    @(negedge clk);
    chk("late_mem_resp_ignored2", bus.req_resp, '0);
    chk("late_mem_op", {bus.mem_read, bus.mem_write}, 2'b00);
    bus.req_read = 4'b1010;
    run_txn(2, 1'b0, 1'b0);
    bus.req_read = '0;

    // spurious mem_resp while idle
    bus.mem_resp  = 1'b1;
    bus.mem_rdata = rand_line();
    @(negedge clk);
    bus.mem_resp = 1'b0;
    chk("spurious_no_resp", bus.req_resp, '0);
    chk("spurious_rdata_hold", bus.req_rdata, m_rdata);
    @(negedge clk);
    chk("spurious_mem_op", {bus.mem_read, bus.mem_write}, 2'b00);

    // randomized traffic
    for (int k = 0; k < 40; k++) begin
      rm = N'($urandom);
      wm = N'($urandom) & N'($urandom);
      for (int p = 0; p < N; p++) begin
        bus.req_address[p*AW +: AW] = $urandom;
        bus.req_wdata[p*LW +: LW]   = rand_line();
      end
      bus.req_read  = rm;
      bus.req_write = wm;
      if ((rm | wm) == '0) begin
        @(negedge clk);
        chk("rand_idle", {bus.mem_read, bus.mem_write}, 2'b00);
        chk("rand_idle_resp", bus.req_resp, '0);
      end else begin
        run_txn(int'($urandom_range(1, 4)), bit'($urandom_range(0, 1)), 1'b0);
        bus.req_read  = '0;
        bus.req_write = '0;
      end
    end

    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
